// File: rtl/snoop_responder.sv
// snoop_responder: dcache-side coherence responder.
// Holds the per-way MSI state / tag arrays, answers bus snoops, and writes
// back Modified blocks (two words) before downgrading them to S or I.

// One way of the state/tag array. Two write ports: the snoop edit and the
// local dcache update. The snoop edit wins when both target the same set.
module snoop_way #(
  parameter int SETS = 8,
  parameter int IDXW = 3,
  parameter int TAGW = 26
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            se_en,
  input  logic [IDXW-1:0] se_set,
  input  logic [1:0]      se_state,
  input  logic            up_en,
  input  logic [IDXW-1:0] up_set,
  input  logic [TAGW-1:0] up_tag,
  input  logic [1:0]      up_state,
  input  logic [IDXW-1:0] snp_set,
  output logic [1:0]      snp_state,
  output logic [TAGW-1:0] snp_tag,
  input  logic [IDXW-1:0] lk_set,
  output logic [1:0]      lk_state,
  output logic [TAGW-1:0] lk_tag
);
  logic [SETS-1:0][1:0]      st;
  logic [SETS-1:0][TAGW-1:0] tg;

  // State/tag storage; snoop edit takes priority over a colliding update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st <= '0;
      tg <= '0;
    end else begin
      if (up_en && !(se_en && se_set == up_set)) begin
        st[up_set] <= up_state;
        tg[up_set] <= up_tag;
      end
      if (se_en) st[se_set] <= se_state;
    end
  end

  assign snp_state = st[snp_set];
  assign snp_tag   = tg[snp_set];
  assign lk_state  = st[lk_set];
  assign lk_tag    = tg[lk_set];
endmodule

module snoop_responder #(
  parameter int SETS = 8,
  parameter int WAYS = 2,
  localparam int IDXW = $clog2(SETS),
  localparam int TAGW = 29 - IDXW
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ccwait,
  input  logic                 ccinv,
  input  logic [31:0]          ccsnoopaddr,
  input  logic                 dwait,
  output logic                 ccwrite,
  output logic                 dWEN,
  output logic [31:0]          daddr,
  output logic [31:0]          dstore,
  output logic                 snp_busy,
  output logic [IDXW-1:0]      dat_set,
  output logic                 dat_way,
  output logic                 dat_off,
  input  logic [31:0]          dat_rdata,
  input  logic                 upd_en,
  input  logic [IDXW-1:0]      upd_set,
  input  logic                 upd_way,
  input  logic [TAGW-1:0]      upd_tag,
  input  logic [1:0]           upd_state,
  output logic [2*WAYS-1:0]    lk_state,
  output logic [WAYS*TAGW-1:0] lk_tag
);
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [1:0] {IDLE, WB0, WB1, HOLD} fsm_e;

  typedef struct packed {
    logic            en;
    logic [IDXW-1:0] set;
    logic            way;
    logic [1:0]      state;
  } st_wr_t;

  fsm_e            fsm;
  logic [IDXW-1:0] set_q;
  logic            way_q;
  logic [TAGW-1:0] tag_q;
  logic            inv_q;
  logic            ccw_q;

  logic [TAGW-1:0] snp_tag;
  logic [IDXW-1:0] snp_idx;
  logic            unused_addr_bits;

  logic [WAYS-1:0][1:0]      way_state;
  logic [WAYS-1:0][TAGW-1:0] way_tag;

  logic       hit;
  logic       hit_way;
  logic [1:0] hit_st;
  logic       hit_m;
  st_wr_t     se;
  logic       upd_ok;
  logic       wb_act;

  assign snp_tag          = ccsnoopaddr[31:3+IDXW];
  assign snp_idx          = ccsnoopaddr[2+IDXW:3];
  assign unused_addr_bits = ^ccsnoopaddr[2:0];

  // Hit lookup across ways; lowest way wins, 2'b11 counts as invalid.
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    hit_st  = ST_I;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if ((way_state[w] == ST_S || way_state[w] == ST_M) && way_tag[w] == snp_tag) begin
        hit     = 1'b1;
        hit_way = 1'(w);
        hit_st  = way_state[w];
      end
    end
  end

  assign hit_m = hit && hit_st == ST_M;

  // Snoop-side state edits: S-hit invalidation in IDLE, downgrade after WB1.
  always_comb begin
    se       = '0;
    se.set   = set_q;
    se.way   = way_q;
    se.state = ST_I;
    if (fsm == IDLE && ccwait && hit && hit_st == ST_S && ccinv) begin
      se.en  = 1'b1;
      se.set = snp_idx;
      se.way = hit_way;
    end else if (fsm == WB1 && ccwait && !dwait) begin
      se.en    = 1'b1;
      se.state = (inv_q | ccinv) ? ST_I : ST_S;
    end
  end

  // Local updates only land while the responder is idle (incl. a snoop's first cycle).
  assign upd_ok = upd_en && fsm == IDLE;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    snoop_way #(.SETS(SETS), .IDXW(IDXW), .TAGW(TAGW)) u_way (
      .CLK      (CLK),
      .RST      (RST),
      .se_en    (se.en && se.way == 1'(g)),
      .se_set   (se.set),
      .se_state (se.state),
      .up_en    (upd_ok && upd_way == 1'(g)),
      .up_set   (upd_set),
      .up_tag   (upd_tag),
      .up_state (upd_state),
      .snp_set  (snp_idx),
      .snp_state(way_state[g]),
      .snp_tag  (way_tag[g]),
      .lk_set   (upd_set),
      .lk_state (lk_state[2*g +: 2]),
      .lk_tag   (lk_tag[TAGW*g +: TAGW])
    );
  end

  // Snoop FSM: latch the snooped block, run the 2-word writeback, hold until ccwait drops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm   <= IDLE;
      set_q <= '0;
      way_q <= 1'b0;
      tag_q <= '0;
      inv_q <= 1'b0;
      ccw_q <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (ccwait) begin
          set_q <= snp_idx;
          way_q <= hit_way;
          tag_q <= snp_tag;
          inv_q <= ccinv;
          ccw_q <= hit_m;
          fsm   <= hit_m ? WB0 : HOLD;
        end
        WB0: if (!ccwait) begin
          ccw_q <= 1'b0;
          fsm   <= IDLE;
        end else begin
          inv_q <= inv_q | ccinv;
          if (!dwait) fsm <= WB1;
        end
        WB1: if (!ccwait) begin
          ccw_q <= 1'b0;
          fsm   <= IDLE;
        end else begin
          inv_q <= inv_q | ccinv;
          if (!dwait) fsm <= HOLD;
        end
        HOLD: if (!ccwait) begin
          ccw_q <= 1'b0;
          fsm   <= IDLE;
        end else begin
          inv_q <= inv_q | ccinv;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Writeback port is only driven while ccwait stays up, so an abort drops dWEN at once.
  assign wb_act   = (fsm == WB0 || fsm == WB1) && ccwait;
  assign ccwrite  = (fsm == IDLE) ? (ccwait && hit_m) : ccw_q;
  assign snp_busy = ccwait || fsm != IDLE;
  assign dWEN     = wb_act;
  assign dat_set  = wb_act ? set_q : '0;
  assign dat_way  = wb_act && way_q;
  assign dat_off  = wb_act && fsm == WB1;
  assign daddr    = wb_act ? {tag_q, set_q, dat_off, 2'b00} : 32'd0;
  assign dstore   = wb_act ? dat_rdata : 32'd0;
endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder: per-cycle vector table plus hand sequences
// for dwait stalls, writeback abort and reset during writeback.
module tb_snoop_responder;
  localparam logic [1:0] S = 2'b01;
  localparam logic [1:0] M = 2'b10;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ccwait, ccinv, dwait;
  logic [31:0] ccsnoopaddr;
  logic        ccwrite, dWEN, snp_busy;
  logic [31:0] daddr, dstore, dat_rdata;
  logic [2:0]  dat_set;
  logic        dat_way, dat_off;
  logic        upd_en, upd_way;
  logic [2:0]  upd_set;
  logic [25:0] upd_tag;
  logic [1:0]  upd_state;
  logic [3:0]  lk_state;
  logic [51:0] lk_tag;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  snoop_responder dut (
    .CLK(CLK), .RST(RST), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dwait(dwait), .ccwrite(ccwrite), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .snp_busy(snp_busy), .dat_set(dat_set), .dat_way(dat_way), .dat_off(dat_off),
    .dat_rdata(dat_rdata), .upd_en(upd_en), .upd_set(upd_set), .upd_way(upd_way),
    .upd_tag(upd_tag), .upd_state(upd_state), .lk_state(lk_state), .lk_tag(lk_tag)
  );

  // Data array model: word value encodes set, way and offset.
  always_comb
    dat_rdata = 32'hA000_0000 + {21'd0, dat_set, 8'd0} + {27'd0, dat_way, 4'd0} + {31'd0, dat_off};

  typedef struct {
    string       n;
    logic        cw, ci;
    logic [31:0] a;
    logic        dw, ue, uw;
    logic [1:0]  ust;
    logic        ecc, ew;
    logic [31:0] ea, es;
    logic        eb;
    logic [3:0]  elk;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic cw, input logic ci, input logic [31:0] a,
                              input logic dw, input logic ue, input logic uw, input logic [1:0] ust,
                              input logic ecc, input logic ew, input logic [31:0] ea,
                              input logic [31:0] es, input logic eb, input logic [3:0] elk);
    vec_t v;
    v.n = n; v.cw = cw; v.ci = ci; v.a = a; v.dw = dw; v.ue = ue; v.uw = uw; v.ust = ust;
    v.ecc = ecc; v.ew = ew; v.ea = ea; v.es = es; v.eb = eb; v.elk = elk;
    return v;
  endfunction

  task automatic idle_in();
    ccwait = 0; ccinv = 0; ccsnoopaddr = 0; dwait = 0;
    upd_en = 0; upd_set = 3'd3; upd_way = 0; upd_tag = 26'd3; upd_state = 0;
  endtask

  initial begin
    // Snoop address 0xD8 -> set 3, tag 3, word 0.
    vecs.push_back(mk("reset_idle",    0,0,32'h0,  0,0,0,0, 0,0,32'h0,0,0,4'h0));
    vecs.push_back(mk("upd_m",         0,0,32'h0,  0,1,0,M, 0,0,32'h0,0,0,4'h0));
    vecs.push_back(mk("snp_m_first",   1,0,32'hD8, 0,0,0,0, 1,0,32'h0,0,1,4'h2));
    vecs.push_back(mk("wb0",           1,0,32'hD8, 0,0,0,0, 1,1,32'hD8,32'hA000_0300,1,4'h2));
    vecs.push_back(mk("wb1",           1,0,32'hD8, 0,0,0,0, 1,1,32'hDC,32'hA000_0301,1,4'h2));
    vecs.push_back(mk("hold",          1,0,32'hD8, 0,0,0,0, 1,0,32'h0,0,1,4'h1));
    vecs.push_back(mk("hold_drop",     0,0,32'h0,  0,0,0,0, 1,0,32'h0,0,1,4'h1));
    vecs.push_back(mk("idle_s",        0,0,32'h0,  0,0,0,0, 0,0,32'h0,0,0,4'h1));
    vecs.push_back(mk("snp_tagmiss",   1,1,32'h1D8,0,0,0,0, 0,0,32'h0,0,1,4'h1));
    vecs.push_back(mk("miss_drop",     0,0,32'h0,  0,0,0,0, 0,0,32'h0,0,1,4'h1));
    vecs.push_back(mk("miss_kept_s",   0,0,32'h0,  0,0,0,0, 0,0,32'h0,0,0,4'h1));
    vecs.push_back(mk("snp_s_inv",     1,1,32'hD8, 0,0,0,0, 0,0,32'h0,0,1,4'h1));
    vecs.push_back(mk("s_inv_hold",    1,0,32'hD8, 0,0,0,0, 0,0,32'h0,0,1,4'h0));
    vecs.push_back(mk("s_inv_drop",    0,0,32'h0,  0,0,0,0, 0,0,32'h0,0,1,4'h0));
    vecs.push_back(mk("upd_s",         0,0,32'h0,  0,1,0,S, 0,0,32'h0,0,0,4'h0));
    vecs.push_back(mk("snp_vs_upd",    1,1,32'hD8, 0,1,0,M, 0,0,32'h0,0,1,4'h1));
    vecs.push_back(mk("hold_upd",      1,0,32'hD8, 0,1,1,M, 0,0,32'h0,0,1,4'h0));
    vecs.push_back(mk("hold_upd_drop", 0,0,32'h0,  0,0,0,0, 0,0,32'h0,0,1,4'h0));
    vecs.push_back(mk("idle_i",        0,0,32'h0,  0,0,0,0, 0,0,32'h0,0,0,4'h0));
    vecs.push_back(mk("upd_w1_m",      0,0,32'h0,  0,1,1,M, 0,0,32'h0,0,0,4'h0));
    vecs.push_back(mk("snp_w1",        1,1,32'hD8, 0,0,0,0, 1,0,32'h0,0,1,4'h8));
    vecs.push_back(mk("wb0_w1",        1,0,32'hD8, 0,0,0,0, 1,1,32'hD8,32'hA000_0310,1,4'h8));
    vecs.push_back(mk("wb1_w1",        1,0,32'hD8, 0,0,0,0, 1,1,32'hDC,32'hA000_0311,1,4'h8));
    vecs.push_back(mk("w1_drop",       0,0,32'h0,  0,0,0,0, 1,0,32'h0,0,1,4'h0));
    vecs.push_back(mk("idle_w1_i",     0,0,32'h0,  0,0,0,0, 0,0,32'h0,0,0,4'h0));

    idle_in();
    RST = 1;
    repeat (2) @(negedge CLK);
    RST = 0;

    // Table: drive at negedge, check combinational/registered outputs before the next edge.
    foreach (vecs[i]) begin
      @(negedge CLK);
      idle_in();
      ccwait = vecs[i].cw; ccinv = vecs[i].ci; ccsnoopaddr = vecs[i].a; dwait = vecs[i].dw;
      upd_en = vecs[i].ue; upd_way = vecs[i].uw; upd_state = vecs[i].ust;
      #1;
      chk({vecs[i].n, ".ccwrite"}, {31'd0, ccwrite}, {31'd0, vecs[i].ecc});
      chk({vecs[i].n, ".dWEN"}, {31'd0, dWEN}, {31'd0, vecs[i].ew});
      chk({vecs[i].n, ".daddr"}, daddr, vecs[i].ea);
      chk({vecs[i].n, ".dstore"}, dstore, vecs[i].es);
      chk({vecs[i].n, ".busy"}, {31'd0, snp_busy}, {31'd0, vecs[i].eb});
      chk({vecs[i].n, ".lk_state"}, {28'd0, lk_state}, {28'd0, vecs[i].elk});
    end

    // dwait stalls with ccinv: address advances only on accepted words, ends in I.
    @(negedge CLK); idle_in(); upd_en = 1; upd_way = 0; upd_state = M;
    @(negedge CLK); idle_in(); ccwait = 1; ccinv = 1; ccsnoopaddr = 32'hD8; dwait = 1;
    #1 chk("stall.ccwrite", {31'd0, ccwrite}, 32'd1);
    chk("stall.lk_tag", {6'd0, lk_tag[25:0]}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      chk("stall.wb0_wen", {31'd0, dWEN}, 32'd1);
      chk("stall.wb0_addr", daddr, 32'hD8);
    end
    @(negedge CLK); dwait = 0; #1 chk("stall.wb0_go", daddr, 32'hD8);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); dwait = 1; #1;
      chk("stall.wb1_wen", {31'd0, dWEN}, 32'd1);
      chk("stall.wb1_addr", daddr, 32'hDC);
    end
    @(negedge CLK); dwait = 0; #1 chk("stall.wb1_data", dstore, 32'hA000_0301);
    @(negedge CLK); ccwait = 0; ccinv = 0; #1;
    chk("stall.final_i", {28'd0, lk_state}, 32'd0);
    chk("stall.wen_off", {31'd0, dWEN}, 32'd0);

    // Abort: ccwait drops in WB0; block stays M.
    @(negedge CLK); idle_in(); upd_en = 1; upd_way = 0; upd_state = M;
    @(negedge CLK); idle_in(); ccwait = 1; ccsnoopaddr = 32'hD8; dwait = 1;
    #1 chk("abort.ccwrite", {31'd0, ccwrite}, 32'd1);
    @(negedge CLK); #1 chk("abort.wb0_wen", {31'd0, dWEN}, 32'd1);
    @(negedge CLK); ccwait = 0; #1 chk("abort.wen_drop", {31'd0, dWEN}, 32'd0);
    @(negedge CLK); #1;
    chk("abort.ccwrite_off", {31'd0, ccwrite}, 32'd0);
    chk("abort.busy", {31'd0, snp_busy}, 32'd0);
    chk("abort.still_m", {28'd0, lk_state}, 32'h2);

    // Reset in WB1.
    @(negedge CLK); ccwait = 1; ccsnoopaddr = 32'hD8; dwait = 0;
    @(negedge CLK); #1 chk("rst.wb0_addr", daddr, 32'hD8);
    @(negedge CLK); RST = 1; dwait = 1; #1;
    chk("rst.wb1_wen", {31'd0, dWEN}, 32'd1);
    chk("rst.wb1_addr", daddr, 32'hDC);
    @(negedge CLK); RST = 0; ccwait = 0; #1;
    chk("rst.wen", {31'd0, dWEN}, 32'd0);
    chk("rst.busy", {31'd0, snp_busy}, 32'd0);
    chk("rst.ccwrite", {31'd0, ccwrite}, 32'd0);
    chk("rst.daddr", daddr, 32'd0);
    chk("rst.lk_state", {28'd0, lk_state}, 32'd0);
    chk("rst.lk_tag", {6'd0, lk_tag[25:0]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
